jtag_scan_master: RTL and testbench

//   JTAG initiator: drives TCK/TMS/TDI into a 1149.1 TAP and samples TDO. It turns

---
 rtl/jtag_scan_master_if.sv | 21 ++
 rtl/jtag_scan_master.sv | 201 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_scan_master_if.sv
// Command/response channel between a scan host and jtag_scan_master.
interface jtag_scan_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_tlr;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_tlr, cmd_is_ir, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_tlr, cmd_is_ir, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG initiator: expands host IR/DR scan commands into a full TAP walk from
// Run-Test/Idle and back, returning the TDO bits captured during Shift.
module jtag_scan_master #(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_scan_master_if.slave bus,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] WALK_LAST = 5'd5;

  // Each scan state names the TAP state the target occupies during that TCK.
  typedef enum logic [3:0] {
    RESET_WALK, IDLE, TLR_WALK, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } state_e;

  state_e            state_r, state_s;
  logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
  logic              tck_r, tck_s;
  logic              tms_r, tms_s;
  logic              tdi_r, tdi_s;
  logic [4:0]        bit_cnt_r, bit_cnt_s;
  logic [4:0]        len_last_r, len_last_s;
  logic [31:0]       data_r, data_s;
  logic              is_ir_r, is_ir_s;
  logic [31:0]       tdo_sh_r, tdo_sh_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [31:0]       rsp_data_r, rsp_data_s;

  // Index of the last shift bit: length 0 is treated as 1, anything above 32 as 32.
  function automatic logic [4:0] len_to_last(input logic [5:0] len);
    logic [5:0] m1;
    m1 = len - 6'd1;
    if (len == 6'd0) begin
      return 5'd0;
    end else if (len > 6'd32) begin
      return 5'd31;
    end else begin
      return m1[4:0];
    end
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_WALK;
      div_cnt_r   <= {DIV_W{1'b0}};
      tck_r       <= 1'b0;
      tms_r       <= 1'b1;
      tdi_r       <= 1'b0;
      bit_cnt_r   <= 5'd0;
      len_last_r  <= 5'd0;
      data_r      <= 32'd0;
      is_ir_r     <= 1'b0;
      tdo_sh_r    <= 32'd0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
    end else begin
      state_r     <= state_s;
      div_cnt_r   <= div_cnt_s;
      tck_r       <= tck_s;
      tms_r       <= tms_s;
      tdi_r       <= tdi_s;
      bit_cnt_r   <= bit_cnt_s;
      len_last_r  <= len_last_s;
      data_r      <= data_s;
      is_ir_r     <= is_ir_s;
      tdo_sh_r    <= tdo_sh_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
    end
  end

  // Next-state logic: TCK phase timing, TMS/TDI per bit, TDO capture, handshake.
  always_comb begin
    state_s     = state_r;
    div_cnt_s   = div_cnt_r;
    tck_s       = tck_r;
    tms_s       = tms_r;
    tdi_s       = tdi_r;
    bit_cnt_s   = bit_cnt_r;
    len_last_s  = len_last_r;
    data_s      = data_r;
    is_ir_s     = is_ir_r;
    tdo_sh_s    = tdo_sh_r;
    cmd_ready_s = cmd_ready_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;

    if (state_r == IDLE) begin
      tck_s     = 1'b0;
      tms_s     = 1'b0;
      tdi_s     = 1'b0;
      div_cnt_s = {DIV_W{1'b0}};
      if (cmd_ready_r && bus.cmd_valid) begin
        cmd_ready_s = 1'b0;
        bit_cnt_s   = 5'd0;
        tms_s       = 1'b1;
        tdo_sh_s    = 32'd0;
        len_last_s  = len_to_last(bus.cmd_len);
        data_s      = bus.cmd_data;
        is_ir_s     = bus.cmd_is_ir;
        state_s     = bus.cmd_tlr ? TLR_WALK : RTI;
      end else begin
        cmd_ready_s = 1'b1;
      end
    end else if (div_cnt_r != DIV_LAST) begin
      div_cnt_s = div_cnt_r + DIV_W'(1);
    end else if (!tck_r) begin
      div_cnt_s = {DIV_W{1'b0}};
      tck_s     = 1'b1;
      if (state_r == SHIFT) begin
        tdo_sh_s[bit_cnt_r] = tdo_i;
      end else begin
        tdo_sh_s = tdo_sh_r;
      end
    end else begin
      // Falling TCK: present TMS/TDI for the next bit, or finish.
      div_cnt_s = {DIV_W{1'b0}};
      tck_s     = 1'b0;
      tdi_s     = 1'b0;
      case (state_r)
        RESET_WALK, TLR_WALK: begin
          if (bit_cnt_r == WALK_LAST) begin
            state_s   = IDLE;
            tms_s     = 1'b0;
            bit_cnt_s = 5'd0;
            if (state_r == TLR_WALK) begin
              rsp_valid_s = 1'b1;
              rsp_data_s  = 32'd0;
            end else begin
              rsp_valid_s = 1'b0;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
            tms_s     = (bit_cnt_r != 5'd4);
          end
        end
        RTI: begin
          state_s = SEL_DR;
          tms_s   = is_ir_r;
        end
        SEL_DR: begin
          state_s = is_ir_r ? SEL_IR : CAPTURE;
          tms_s   = 1'b0;
        end
        SEL_IR: begin
          state_s = CAPTURE;
          tms_s   = 1'b0;
        end
        CAPTURE: begin
          state_s   = SHIFT;
          bit_cnt_s = 5'd0;
          tms_s     = (len_last_r == 5'd0);
          tdi_s     = data_r[0];
        end
        SHIFT: begin
          if (bit_cnt_r == len_last_r) begin
            state_s = EXIT1;
            tms_s   = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
            tms_s     = ((bit_cnt_r + 5'd1) == len_last_r);
            tdi_s     = data_r[bit_cnt_r + 5'd1];
          end
        end
        EXIT1: begin
          state_s = UPDATE;
          tms_s   = 1'b0;
        end
        UPDATE: begin
          state_s     = IDLE;
          tms_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_data_s  = tdo_sh_r;
        end
        default: begin
          state_s   = RESET_WALK;
          bit_cnt_s = 5'd0;
          tms_s     = 1'b1;
        end
      endcase
    end
  end

  assign tck_o         = tck_r;
  assign tms_o         = tms_r;
  assign tdi_o         = tdi_r;
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master against a behavioural TAP with IDCODE,
// BYPASS, CSR_ADDR and CSR_DATA registers.
module tb_jtag_scan_master;
  localparam logic [31:0] IDCODE_DATA = 32'h4BA0_0477;
  localparam logic [3:0]  IR_IDCODE   = 4'h1;
  localparam logic [3:0]  IR_CSR_ADDR = 4'h2;
  localparam logic [3:0]  IR_CSR_DATA = 4'h3;
  localparam logic [3:0]  IR_BYPASS   = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck_o, tms_o, tdi_o;
  logic tdo = 1'b0;

  jtag_scan_master_if bus ();

  jtag_scan_master #(.CLK_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tck_o (tck_o),
    .tms_o (tms_o),
    .tdi_o (tdi_o),
    .tdo_i (tdo)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_e;

  tap_e        tap_st = T_TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sh = 4'd0;
  logic [31:0] dr_sh = 32'd0;
  int          dr_len = 1;
  int          tap_shift_cnt = 0;
  logic [2:0]  csr_addr = 3'd0;
  logic [31:0] csr_data = 32'd0;

  function automatic tap_e tap_next(input tap_e s, input logic t);
    case (s)
      T_TLR:  return t ? T_TLR  : T_RTI;
      T_RTI:  return t ? T_SDR  : T_RTI;
      T_SDR:  return t ? T_SIR  : T_CDR;
      T_CDR:  return t ? T_E1DR : T_SHDR;
      T_SHDR: return t ? T_E1DR : T_SHDR;
      T_E1DR: return t ? T_UDR  : T_PDR;
      T_PDR:  return t ? T_E2DR : T_PDR;
      T_E2DR: return t ? T_UDR  : T_SHDR;
      T_UDR:  return t ? T_SDR  : T_RTI;
      T_SIR:  return t ? T_TLR  : T_CIR;
      T_CIR:  return t ? T_E1IR : T_SHIR;
      T_SHIR: return t ? T_E1IR : T_SHIR;
      T_E1IR: return t ? T_UIR  : T_PIR;
      T_PIR:  return t ? T_E2IR : T_PIR;
      T_E2IR: return t ? T_UIR  : T_SHIR;
      T_UIR:  return t ? T_SDR  : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  // Target TAP: actions on rising TCK, TDO driven on falling TCK.
  always @(posedge tck_o) begin
    case (tap_st)
      T_TLR: ir <= IR_IDCODE;
      T_CDR: begin
        tap_shift_cnt <= 0;
        case (ir)
          IR_IDCODE:   begin dr_sh <= IDCODE_DATA;          dr_len <= 32; end
          IR_CSR_ADDR: begin dr_sh <= {29'd0, csr_addr};    dr_len <= 3;  end
          IR_CSR_DATA: begin dr_sh <= csr_data;             dr_len <= 32; end
          default:     begin dr_sh <= 32'd0;                dr_len <= 1;  end
        endcase
      end
      T_SHDR: begin
        dr_sh <= (dr_sh >> 1) | ({31'd0, tdi_o} << (dr_len - 1));
        tap_shift_cnt <= tap_shift_cnt + 1;
      end
      T_UDR: begin
        if (ir == IR_CSR_ADDR) csr_addr <= dr_sh[2:0];
        else if (ir == IR_CSR_DATA) csr_data <= dr_sh;
      end
      T_CIR:  ir_sh <= 4'b0001;
      T_SHIR: ir_sh <= {tdi_o, ir_sh[3:1]};
      T_UIR:  ir <= ir_sh;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    if (tap_st == T_SHDR) tdo <= dr_sh[0];
    else if (tap_st == T_SHIR) tdo <= ir_sh[0];
    else tdo <= 1'b0;
  end

  int          tck_cnt = 0;
  int          rsp_cnt = 0;
  logic [63:0] tms_hist = 64'd0;
  time         last_t = 0;
  time         tck_per = 0;

  always @(posedge tck_o) begin
    tck_cnt  <= tck_cnt + 1;
    tms_hist <= {tms_hist[62:0], tms_o};
    tck_per  <= $time - last_t;
    last_t   <= $time;
  end

  always @(posedge clk) begin
    if (bus.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          timeouts = 0;
  int          tck0, rsp0, ntck, npulse;
  logic [31:0] got_rsp;
  logic        rdy_after;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input logic tlr, input logic is_ir, input logic [5:0] len,
                            input logic [31:0] data);
    int t;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeouts++;
    tck0 = tck_cnt;
    rsp0 = rsp_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_tlr   = tlr;
    bus.cmd_is_ir = is_ir;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    // Scramble the command inputs: the DUT must have latched them already.
    bus.cmd_valid = 1'b0;
    bus.cmd_tlr   = ~tlr;
    bus.cmd_is_ir = ~is_ir;
    bus.cmd_len   = 6'd7;
    bus.cmd_data  = ~data;
    @(negedge clk);
  endtask

  task automatic finish_scan();
    int t;
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) timeouts++;
    got_rsp = bus.rsp_data;
    ntck    = tck_cnt - tck0;
    @(negedge clk);
    rdy_after = bus.cmd_ready;
    npulse    = rsp_cnt - rsp0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_tlr   = 1'b0;
    bus.cmd_is_ir = 1'b0;
    bus.cmd_len   = 6'd0;
    bus.cmd_data  = 32'd0;

    // 1: reset values and the automatic TLR walk
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck_o), 64'd0);
    chk("rst_tms", 64'(tms_o), 64'd1);
    chk("rst_tdi", 64'(tdi_o), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    rst_n = 1'b1;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("walk_timeout", 64'(t >= 200), 64'd0);
    chk("walk_tcks", 64'(tck_cnt), 64'd6);
    chk("walk_tms", 64'(tms_hist[5:0]), 64'b111110);
    chk("walk_no_rsp", 64'(rsp_cnt), 64'd0);
    chk("walk_tap_rti", 64'(tap_st), 64'(T_RTI));
    chk("idle_tck", 64'(tck_o), 64'd0);
    chk("idle_tms", 64'(tms_o), 64'd0);

    // 2: IR scan selecting IDCODE
    start_scan(1'b0, 1'b1, 6'd4, 32'h1);
    finish_scan();
    chk("ir_rsp", 64'(got_rsp), 64'h1);
    chk("ir_tcks", 64'(ntck), 64'd10);
    chk("ir_tms", 64'(tms_hist[9:0]), 64'b1100000110);
    chk("ir_pulses", 64'(npulse), 64'd1);
    chk("ir_ready_after", 64'(rdy_after), 64'd1);
    chk("ir_model", 64'(ir), 64'(IR_IDCODE));

    // 3: 32-bit IDCODE read, TCK period check
    start_scan(1'b0, 1'b0, 6'd32, 32'd0);
    finish_scan();
    chk("idcode_rsp", 64'(got_rsp), 64'(IDCODE_DATA));
    chk("idcode_tcks", 64'(ntck), 64'd37);
    chk("tck_period", 64'(tck_per), 64'd40);
    chk("idcode_tap_rti", 64'(tap_st), 64'(T_RTI));
    chk("post_idle_tck", 64'(tck_o), 64'd0);
    chk("post_idle_tdi", 64'(tdi_o), 64'd0);

    // TLR command
    start_scan(1'b1, 1'b0, 6'd9, 32'hFFFF_FFFF);
    finish_scan();
    chk("tlr_rsp", 64'(got_rsp), 64'd0);
    chk("tlr_tcks", 64'(ntck), 64'd6);
    chk("tlr_tms", 64'(tms_hist[5:0]), 64'b111110);
    chk("tlr_pulses", 64'(npulse), 64'd1);

    // 4: edge lengths
    start_scan(1'b0, 1'b0, 6'd1, 32'h1);
    finish_scan();
    chk("len1_rsp", 64'(got_rsp), 64'h1);
    chk("len1_tcks", 64'(ntck), 64'd6);
    chk("len1_tms", 64'(tms_hist[5:0]), 64'b100110);
    start_scan(1'b0, 1'b0, 6'd0, 32'h0);
    finish_scan();
    chk("len0_rsp", 64'(got_rsp), 64'h1);
    chk("len0_tcks", 64'(ntck), 64'd6);
    start_scan(1'b0, 1'b0, 6'd40, 32'h0);
    finish_scan();
    chk("len40_rsp", 64'(got_rsp), 64'(IDCODE_DATA));
    chk("len40_tcks", 64'(ntck), 64'd37);
    start_scan(1'b0, 1'b1, 6'd4, 32'(IR_BYPASS));
    finish_scan();
    chk("ir_bypass_rsp", 64'(got_rsp), 64'h1);
    start_scan(1'b0, 1'b0, 6'd1, 32'h1);
    finish_scan();
    chk("bypass_rsp", 64'(got_rsp), 64'h0);
    chk("bypass_tcks", 64'(ntck), 64'd6);

    // 5: CSR writes, back-to-back DR scans
    start_scan(1'b0, 1'b1, 6'd4, 32'(IR_CSR_ADDR));
    finish_scan();
    start_scan(1'b0, 1'b0, 6'd3, 32'h5);
    finish_scan();
    chk("csr_addr_rsp", 64'(got_rsp), 64'h0);
    chk("csr_addr_model", 64'(csr_addr), 64'h5);
    start_scan(1'b0, 1'b1, 6'd4, 32'(IR_CSR_DATA));
    finish_scan();
    start_scan(1'b0, 1'b0, 6'd32, 32'hDEAD_BEEF);
    finish_scan();
    chk("csr_data_rsp", 64'(got_rsp), 64'h0);
    chk("csr_data_model", 64'(csr_data), 64'hDEAD_BEEF);
    chk("b2b_ready", 64'(rdy_after), 64'd1);
    start_scan(1'b0, 1'b0, 6'd32, 32'h1234_5678);
    finish_scan();
    chk("csr_readback", 64'(got_rsp), 64'hDEAD_BEEF);
    chk("csr_data_model2", 64'(csr_data), 64'h1234_5678);
    chk("csr_addr_kept", 64'(csr_addr), 64'h5);

    // 6: reset during shift bit 10 of a 32-bit DR scan
    start_scan(1'b0, 1'b1, 6'd4, 32'(IR_IDCODE));
    finish_scan();
    start_scan(1'b0, 1'b0, 6'd32, 32'd0);
    t = 0;
    while (!(tap_st == T_SHDR && tap_shift_cnt >= 10 && tck_o === 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("midscan_timeout", 64'(t >= 500), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_tck", 64'(tck_o), 64'd0);
    chk("abort_tms", 64'(tms_o), 64'd1);
    chk("abort_tdi", 64'(tdi_o), 64'd0);
    chk("abort_ready", 64'(bus.cmd_ready), 64'd0);
    chk("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tck0 = tck_cnt;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rewalk_timeout", 64'(t >= 200), 64'd0);
    chk("rewalk_tcks", 64'(tck_cnt - tck0), 64'd6);
    chk("rewalk_tms", 64'(tms_hist[5:0]), 64'b111110);
    chk("abort_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    chk("rewalk_tap_rti", 64'(tap_st), 64'(T_RTI));
    start_scan(1'b0, 1'b0, 6'd32, 32'd0);
    finish_scan();
    chk("post_abort_idcode", 64'(got_rsp), 64'(IDCODE_DATA));
    chk("post_abort_tcks", 64'(ntck), 64'd37);

    chk("handshake_timeouts", 64'(timeouts), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
